// File: rtl/slave_nonce_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slave_nonce_tx_pkg
// Description : Link constants shared by the hub-side receiver and the
//               external-miner transmitter: UART framing and bit period.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef SLAVE_NONCE_TX_PKG_SV
`define SLAVE_NONCE_TX_PKG_SV

// Bit period in clk cycles, rounded to nearest; both ends of the link use it.
`define SNT_BIT_DIV(clk_hz, baud) (((clk_hz) + ((baud) / 2)) / (baud))

package slave_nonce_tx_pkg;
  localparam int   DATA_BITS       = 8;
  localparam int   BYTES_PER_NONCE = 4;
  localparam logic START_LEVEL     = 1'b0;
  localparam logic STOP_LEVEL      = 1'b1;
  localparam logic IDLE_LEVEL      = 1'b1;
endpackage

`endif
`default_nettype wire

// File: rtl/slave_nonce_tx_nonce_fifo.sv
`default_nettype none
// ============================================================================
// Module      : nonce_fifo
// Description : Small synchronous FIFO that absorbs golden-nonce bursts while
//               the serial line is busy. Registered empty/full flags.
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_fifo #(
  parameter int WIDTH = 32,
  parameter int LOG2  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int             c_depth      = 1 << LOG2;
  localparam logic [LOG2:0]  c_full_count = {1'b1, {LOG2{1'b0}}};

  logic [WIDTH-1:0] r_mem [c_depth];
  logic [LOG2-1:0]  r_wr_ptr;
  logic [LOG2-1:0]  r_rd_ptr;
  logic [LOG2:0]    r_count;
  logic [LOG2:0]    w_count_next;
  logic             r_empty;
  logic             r_full;
  logic             w_pop_ok;
  logic             w_push_ok;

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
  // when a pop frees a slot in the same cycle.
  assign w_pop_ok  = pop && !r_empty;
  assign w_push_ok = push && (!r_full || w_pop_ok);

  // Occupancy after this edge; simultaneous push and pop cancel out.
  always_comb begin
    w_count_next = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_next = r_count + (LOG2+1)'(1);
      2'b01:   w_count_next = r_count - (LOG2+1)'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + LOG2'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + LOG2'(1);
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == c_full_count);
    end
  end

  // Storage needs no reset; validity is tracked by the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = r_empty;
  assign full  = r_full;
endmodule
`default_nettype wire

// File: rtl/slave_nonce_tx.sv
`default_nettype none
// ============================================================================
// Module      : slave_nonce_tx
// Description : Queues golden nonces and sends each as four 8N1 bytes,
//               LSB byte first, followed by one idle bit period for resync.
// Revision    : 1.0 - initial release
// ============================================================================
module slave_nonce_tx
  import slave_nonce_tx_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 115200,
  parameter int FIFO_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] nonce,
  input  logic        nonce_valid,
  output logic        TxD,
  output logic        busy,
  output logic        fifo_full,
  output logic [7:0]  drop_count
);
  localparam int                c_bit_div  = `SNT_BIT_DIV(CLK_HZ, BAUD);
  localparam int                c_cnt_w    = (c_bit_div > 2) ? $clog2(c_bit_div) : 1;
  localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(c_bit_div - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [c_cnt_w-1:0] r_baud_cnt;
  logic [2:0]         r_bit_idx;
  logic [1:0]         r_byte_idx;
  logic [31:0]        r_shreg;
  logic               r_txd;
  logic               r_busy;
  logic [7:0]         r_drop_count;
  logic               w_bit_done;
  logic               w_pop;
  logic [31:0]        w_fifo_dout;
  logic               w_fifo_empty;
  logic               w_fifo_full;

  nonce_fifo #(
    .WIDTH (32),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (nonce_valid),
    .din   (nonce),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .empty (w_fifo_empty),
    .full  (w_fifo_full)
  );

  assign w_bit_done = (r_baud_cnt == c_div_last);

  // Load a word from IDLE, or straight out of the last GAP cycle so that the
  // inter-word idle is exactly one bit period.
  assign w_pop = !w_fifo_empty &&
                 ((r_state == S_IDLE) || ((r_state == S_GAP) && w_bit_done));

  // Frame sequencing: START, 8 x DATA, STOP per byte, four bytes, then GAP.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_fifo_empty) w_state_next = S_START;
      S_START: if (w_bit_done) w_state_next = S_DATA;
      S_DATA:  if (w_bit_done && (r_bit_idx == 3'(DATA_BITS - 1))) w_state_next = S_STOP;
      S_STOP:  if (w_bit_done) w_state_next = (r_byte_idx == 2'(BYTES_PER_NONCE - 1)) ? S_GAP : S_START;
      S_GAP:   if (w_bit_done) w_state_next = w_fifo_empty ? S_IDLE : S_START;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, baud counter and bit/byte position tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) || w_bit_done || (w_state_next != r_state))
        r_baud_cnt <= '0;
      else
        r_baud_cnt <= r_baud_cnt + c_cnt_w'(1);
      if ((r_state == S_START) && w_bit_done)
        r_bit_idx <= '0;
      else if ((r_state == S_DATA) && w_bit_done)
        r_bit_idx <= r_bit_idx + 3'd1;
      if (w_pop)
        r_byte_idx <= '0;
      else if ((r_state == S_STOP) && w_bit_done && (w_state_next == S_START))
        r_byte_idx <= r_byte_idx + 2'd1;
    end
  end

  // Word shift register: whole nonce loaded on pop, one bit consumed per data bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_shreg <= '0;
    else if (w_pop)
      r_shreg <= w_fifo_dout;
    else if ((r_state == S_DATA) && w_bit_done)
      r_shreg <= {1'b0, r_shreg[31:1]};
  end

  // Registered line driver; async reset forces the line idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txd <= IDLE_LEVEL;
    end else begin
      case (r_state)
        S_START: r_txd <= START_LEVEL;
        S_DATA:  r_txd <= r_shreg[0];
        S_STOP:  r_txd <= STOP_LEVEL;
        default: r_txd <= IDLE_LEVEL;
      endcase
    end
  end

  // Activity flag and saturating overflow counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_busy <= (r_state != S_IDLE) || !w_fifo_empty;
      if (nonce_valid && w_fifo_full && !w_pop && (r_drop_count != 8'hFF))
        r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign TxD        = r_txd;
  assign busy       = r_busy;
  assign fifo_full  = w_fifo_full;
  assign drop_count = r_drop_count;
endmodule
`default_nettype wire

// File: tb/tb_slave_nonce_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_slave_nonce_tx
// Description : Self-checking bench for slave_nonce_tx with a word-level
//               reference model of the line schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slave_nonce_tx;
  localparam int BD        = 8;          // (800 + 50) / 100
  localparam int DEPTH     = 4;
  localparam int FRAME     = 40 * BD;    // 4 bytes x 10 bits
  localparam int WORD_CLKS = 41 * BD;    // frame plus one idle bit period

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] nonce = '0;
  logic        nonce_valid = 1'b0;
  logic        TxD;
  logic        busy;
  logic        fifo_full;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  slave_nonce_tx #(
    .CLK_HZ    (800),
    .BAUD      (100),
    .FIFO_LOG2 (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .nonce       (nonce),
    .nonce_valid (nonce_valid),
    .TxD         (TxD),
    .busy        (busy),
    .fifo_full   (fifo_full),
    .drop_count  (drop_count)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model state: queued words, word on the line and when it started.
  logic [31:0] q[$];
  bit          have_word = 0;
  int          t_take = 0;
  int          line_free = 0;
  logic [31:0] cur = '0;
  int          drops = 0;
  logic        exp_txd = 1'b1;
  logic        exp_busy = 1'b0;
  logic        exp_full = 1'b0;
  bit          txd_log [0:99999];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    have_word = 0;
    line_free = 0;
    drops = 0;
  endtask

  // One clock edge of the model, using the inputs presented on that edge.
  task automatic model_edge();
    int  cnt;
    bit  take;
    int  j;
    cnt = q.size();
    exp_busy = (have_word && (cyc - 1 >= t_take) && (cyc - 1 < t_take + WORD_CLKS)) || (cnt > 0);
    take = (cnt > 0) && (cyc >= line_free);
    if (take) begin
      cur = q.pop_front();
      t_take = cyc;
      line_free = cyc + WORD_CLKS;
      have_word = 1;
    end
    if (nonce_valid) begin
      if (cnt < DEPTH || take) q.push_back(nonce);
      else if (drops < 255) drops++;
    end
    exp_full = (q.size() == DEPTH);
    exp_txd = 1'b1;
    if (have_word && cyc >= t_take + 1 && cyc <= t_take + FRAME) begin
      j = (cyc - t_take - 1) / BD;
      case (j % 10)
        0:       exp_txd = 1'b0;
        9:       exp_txd = 1'b1;
        default: exp_txd = cur[8 * (j / 10) + (j % 10) - 1];
      endcase
    end
  endtask

  task automatic step(input bit v, input logic [31:0] d);
    nonce_valid = v;
    nonce = d;
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    if (cyc < 100000) txd_log[cyc] = TxD;
    check("TxD", TxD, exp_txd);
    check("busy", busy, exp_busy);
    check("fifo_full", fifo_full, exp_full);
    check("drop_count", drop_count, drops);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  initial begin
    int          e;
    int          first_low;
    logic [7:0]  got;
    logic [7:0]  exp_bytes [4];

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_TxD", TxD, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_drop_count", drop_count, 0);
    rst_n = 1'b1;
    idle(5);

    // Single word: latency and byte decode of 0x12345678.
    e = cyc + 1;
    step(1'b1, 32'h12345678);
    idle(340);
    first_low = -1;
    for (int k = e; k <= e + 20; k++)
      if (first_low < 0 && txd_log[k] == 1'b0) first_low = k;
    check("start_latency", first_low, e + 2);
    exp_bytes[0] = 8'h78; exp_bytes[1] = 8'h56; exp_bytes[2] = 8'h34; exp_bytes[3] = 8'h12;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++)
        got[i] = txd_log[e + 2 + BD * (10 * b + 1 + i) + BD / 2];
      check("decoded_byte", got, exp_bytes[b]);
      check("stop_bit", txd_log[e + 2 + BD * (10 * b + 9) + BD / 2], 1);
    end
    check("idle_after_word", busy, 0);

    // Two words on consecutive cycles: second start exactly one idle period later.
    e = cyc + 1;
    step(1'b1, 32'hA5000001);
    step(1'b1, 32'hFFFFFFFF);
    idle(700);
    check("gap_last_high", txd_log[e + 2 + FRAME + BD - 1], 1);
    check("word2_start", txd_log[e + 2 + WORD_CLKS], 0);

    // Six back-to-back pushes: one popped, four queued, one dropped.
    for (int i = 0; i < 6; i++) step(1'b1, 32'h1000 + i);
    check("burst_full", fifo_full, 1);
    check("burst_drop", drop_count, 1);
    // Keep strobing while full: counter must saturate.
    for (int i = 0; i < 300; i++) step(1'b1, 32'hBAD0000 + i);
    check("drop_saturated", drop_count, 255);
    idle(5 * WORD_CLKS + 40);
    check("burst_drained", busy, 0);

    // Reset in the middle of byte 2, bit 4, with another word queued.
    step(1'b1, 32'hC0FFEE11);
    step(1'b1, 32'h0BADF00D);
    idle(203);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_TxD", TxD, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_full", fifo_full, 0);
    check("async_rst_drop", drop_count, 0);
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    check("held_rst_TxD", TxD, 1);
    rst_n = 1'b1;
    model_reset();
    idle(20);
    e = cyc + 1;
    step(1'b1, 32'h00000000);
    idle(340);
    check("post_rst_start", txd_log[e + 2], 0);
    check("post_rst_data", txd_log[e + 2 + BD + BD / 2], 0);

    // Randomized traffic, including bursts that overflow the FIFO.
    for (int n = 0; n < 150; n++) begin
      step(1'b1, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 3));
      else idle($urandom_range(0, 350));
    end
    idle(DEPTH * WORD_CLKS + 2 * WORD_CLKS);
    check("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
